// File: rtl/cdc_hs_pkg.sv
// Shared definitions for the cdc_hs req/ack handshake pair (transmitter and
// receiver): FSM state encodings, default synchronizer depth and a clog2 helper.
package cdc_hs_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  localparam int DEFAULT_SYNC_STAGES = 2;

  // Ceiling log2 for elaboration-time width computation; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cdc_bit_sync.sv
// Single-bit multi-flop synchronizer. The asynchronous input d enters the
// first flop; q is the last flop of a STAGES-deep chain. Synchronous
// active-high reset clears the whole chain so no stale value survives reset.
module cdc_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous bit through the chain, one flop per cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Source-domain end of a 4-phase req/ack handshake. A word accepted over
// in_valid/in_ready is held on data_o while req_o is raised; the FSM waits for
// the synchronized ack to rise, drops req_o, waits for ack to fall, then
// pulses done_o and returns to IDLE.
//
// Handshake: a word transfers on a rising clk_i edge where in_valid_i and
// in_ready_o are both 1; in_ready_o is 1 only in IDLE (and never during reset),
// so offers made while busy are simply ignored and not buffered.
//
// Optional feature, macro CDC_HS_TX_TIMEOUT_EN: adds a sticky timeout_o that
// sets after TIMEOUT_CYCLES cycles without a state change in REQ or WAIT_LOW.
// state_o exposes the FSM state for debug observation.
module cdc_hs_tx
  import cdc_hs_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic                  req_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ack_i,
  output logic                  done_o,
  output logic                  busy_o,
  output state_t                state_o
`ifdef CDC_HS_TX_TIMEOUT_EN
  ,
  output logic                  timeout_o
`endif
);

  // Reject illegal configurations at elaboration.
  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("cdc_hs_tx: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  state_t state;
  logic   ack_s;

  cdc_bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d    (ack_i),
    .q    (ack_s)
  );

  assign in_ready_o = (state == IDLE) && !rst_i;
  assign state_o    = state;

  // Handshake FSM with registered req/data/done/busy outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      req_o  <= 1'b0;
      data_o <= '0;
      done_o <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            data_o <= in_data_i;
            req_o  <= 1'b1;
            busy_o <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (ack_s) begin
            req_o <= 1'b0;
            state <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!ack_s) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          req_o  <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

`ifdef CDC_HS_TX_TIMEOUT_EN
  localparam int                CNT_W   = clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic             state_change;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign state_change = (state == IDLE     && in_valid_i && in_ready_o) ||
                        (state == REQ      && ack_s) ||
                        (state == WAIT_LOW && !ack_s);
  assign cnt_inc      = cnt + 1'b1;

  // Cycles spent in the current busy state; saturates at the limit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (state_change) begin
      cnt <= '0;
    end else if (state != IDLE && cnt != CNT_MAX) begin
      cnt <= cnt_inc;
    end
  end

  // Sticky flag set on the edge where the count reaches the limit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timeout_o <= 1'b0;
    end else if (!state_change && state != IDLE && cnt_inc == CNT_MAX) begin
      timeout_o <= 1'b1;
    end
  end
`endif

endmodule
